// File: rtl/grid_scan_driver.sv
// grid_scan_driver: row-multiplexed 7x7 LED matrix driver for the Life grid.
// Double-buffered so a new generation only appears at a frame boundary.
module grid_scan_driver #(
    parameter int ROWS  = 7,
    parameter int COLS  = 7,
    parameter int DWELL = 1000,
    parameter int BLANK = 8
) (
    input  logic                 clka,
    input  logic                 stop,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] grid,
    input  logic                 grid_valid,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_data,
    output logic                 frame_start,
    output logic                 pending
);

    localparam int N    = ROWS * COLS;
    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [RW-1:0] row;
    logic [RW-1:0] row_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          swap;

    logic [N-1:0]  shadow;
    logic [N-1:0]  shadow_n;
    logic [N-1:0]  pend_buf;
    logic [N-1:0]  pend_buf_n;
    logic          pending_n;

    logic [ROWS-1:0] row_sel_n;
    logic [COLS-1:0] col_data_n;
    logic            frame_start_n;

    // Scan sequencer: idle -> blank -> show row, one row per blank/show pair.
    always_comb begin
        state_n = state;
        row_n   = row;
        cnt_n   = cnt;
        swap    = 1'b0;
        if (!enable) begin
            state_n = S_IDLE;
            row_n   = '0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_n = S_BLANK;
                    row_n   = '0;
                    cnt_n   = '0;
                    swap    = 1'b1;
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n = S_SHOW;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        state_n = S_BLANK;
                        cnt_n   = '0;
                        if (row == ROW_LAST) begin
                            row_n = '0;
                            swap  = 1'b1;
                        end else begin
                            row_n = row + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    row_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Capture new generations; at a frame boundary the newest one wins.
    always_comb begin
        pend_buf_n = pend_buf;
        pending_n  = pending;
        shadow_n   = shadow;
        if (grid_valid) begin
            pend_buf_n = grid;
            pending_n  = 1'b1;
        end
        if (swap) begin
            if (grid_valid) begin
                shadow_n = grid;
            end else if (pending) begin
                shadow_n = pend_buf;
            end
            pending_n = 1'b0;
        end
    end

    // Matrix drive for the upcoming cycle, so outputs register with state.
    always_comb begin
        row_sel_n     = '0;
        col_data_n    = '0;
        frame_start_n = 1'b0;
        if (state_n == S_SHOW) begin
            row_sel_n     = ROWS'(1) << row_n;
            col_data_n    = shadow_n[int'(row_n) * COLS +: COLS];
            frame_start_n = (state != S_SHOW) && (row_n == '0);
        end
    end

    // Sequencer state and registered matrix outputs.
    always_ff @(posedge clka) begin
        if (stop) begin
            state       <= S_IDLE;
            row         <= '0;
            cnt         <= '0;
            row_sel     <= '0;
            col_data    <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            cnt         <= cnt_n;
            row_sel     <= row_sel_n;
            col_data    <= col_data_n;
            frame_start <= frame_start_n;
        end
    end

    // Frame buffers: displayed shadow and waiting pend_buf.
    always_ff @(posedge clka) begin
        if (stop) begin
            shadow   <= '0;
            pend_buf <= '0;
            pending  <= 1'b0;
        end else begin
            shadow   <= shadow_n;
            pend_buf <= pend_buf_n;
            pending  <= pending_n;
        end
    end

endmodule
